// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (core / NIC) in front of one single-port synchronous data memory.
// Per-cycle grant, registered memory command, tagged read return, saturating grant counters.
module dmem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int MEM_LATENCY = 1,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prio_mode,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    output logic                  c_gnt,
    output logic                  c_stall,
    output logic                  c_rvalid,
    output logic [DATA_WIDTH-1:0] c_rdata,
    input  logic                  n_req,
    input  logic                  n_we,
    input  logic [ADDR_WIDTH-1:0] n_addr,
    input  logic [DATA_WIDTH-1:0] n_wdata,
    output logic                  n_gnt,
    output logic                  n_rvalid,
    output logic [DATA_WIDTH-1:0] n_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [CNT_WIDTH-1:0]  c_gnt_cnt,
    output logic [CNT_WIDTH-1:0]  n_gnt_cnt
);

    logic                 rr_ptr;
    logic                 mem_en_q;
    logic                 mem_we_q;
    logic [MEM_LATENCY:0] tag_v;
    logic [MEM_LATENCY:0] tag_id;
    logic                 any_gnt;
    logic                 gnt_we;
    logic                 core_wins;

    // Core wins when alone, under fixed priority, or when the NIC was granted last.
    assign core_wins = ~n_req | prio_mode | rr_ptr;
    assign c_gnt     = ~rst & c_req & core_wins;
    assign n_gnt     = ~rst & n_req & ~c_gnt;
    assign c_stall   = c_req & ~c_gnt;
    assign any_gnt   = c_gnt | n_gnt;
    assign gnt_we    = c_gnt ? c_we : n_we;

    // A command latched just before reset must not reach the memory.
    assign mem_en = mem_en_q & ~rst;
    assign mem_we = mem_we_q & ~rst;

    assign c_rvalid = ~rst & tag_v[MEM_LATENCY] & ~tag_id[MEM_LATENCY];
    assign n_rvalid = ~rst & tag_v[MEM_LATENCY] & tag_id[MEM_LATENCY];
    assign c_rdata  = mem_dout;
    assign n_rdata  = mem_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= 1'b1;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            mem_en_q <= any_gnt;
            mem_we_q <= any_gnt & gnt_we;
            if (any_gnt) begin
                rr_ptr   <= n_gnt;
                mem_addr <= c_gnt ? c_addr : n_addr;
                mem_din  <= c_gnt ? c_wdata : n_wdata;
            end
        end
    end

    // Stage k holds the tag of a read granted k+1 cycles ago.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v  <= {tag_v[MEM_LATENCY-1:0], any_gnt & ~gnt_we};
            tag_id <= {tag_id[MEM_LATENCY-1:0], n_gnt};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_gnt_cnt <= '0;
            n_gnt_cnt <= '0;
        end else begin
            if (c_gnt && c_gnt_cnt != '1)
                c_gnt_cnt <= c_gnt_cnt + CNT_WIDTH'(1);
            if (n_gnt && n_gnt_cnt != '1)
                n_gnt_cnt <= n_gnt_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a latency-1 synchronous memory model.
// Built with CNT_WIDTH=4 so counter saturation is reachable quickly.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          prio_mode;
    logic          c_req, c_we, n_req, n_we;
    logic [AW-1:0] c_addr, n_addr;
    logic [DW-1:0] c_wdata, n_wdata;
    logic          c_gnt, c_stall, c_rvalid, n_gnt, n_rvalid;
    logic [DW-1:0] c_rdata, n_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic [CW-1:0] c_gnt_cnt, n_gnt_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] mem [0:255];

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .prio_mode(prio_mode),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .n_req(n_req), .n_we(n_we), .n_addr(n_addr), .n_wdata(n_wdata),
        .n_gnt(n_gnt), .n_rvalid(n_rvalid), .n_rdata(n_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .c_gnt_cnt(c_gnt_cnt), .n_gnt_cnt(n_gnt_cnt)
    );

    // Single-port memory: read data appears the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_din;
            else        mem_dout <= mem[mem_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive point: 1 time unit after the rising edge; sample at +5 (falling edge).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        #4;
    endtask

    task automatic idle();
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        n_req = 0; n_we = 0; n_addr = '0; n_wdata = '0;
    endtask

    task automatic do_reset();
        cyc(); rst = 1; idle();
        cyc();
        cyc(); rst = 0;
    endtask

    initial begin
        rst = 1; prio_mode = 0; mem_dout = '0; idle();
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 64'hAAAA;
        mem[8'h30] = 64'h3333;
        mem[8'h40] = 64'h4444;

        // 1: core-only read after reset
        do_reset();
        c_req = 1; c_addr = 32'h10;
        smp();
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_cnt", 64'(c_gnt_cnt), 64'd0);
        chk("t1_c_gnt", 64'(c_gnt), 64'd1);
        chk("t1_stall", 64'(c_stall), 64'd0);
        cyc(); c_req = 0;
        smp();
        chk("t1_mem_en", 64'(mem_en), 64'd1);
        chk("t1_mem_we", 64'(mem_we), 64'd0);
        chk("t1_mem_addr", 64'(mem_addr), 64'h10);
        chk("t1_early_rv", 64'(c_rvalid), 64'd0);
        cyc();
        smp();
        chk("t1_c_rvalid", 64'(c_rvalid), 64'd1);
        chk("t1_c_rdata", c_rdata, 64'hAAAA);
        chk("t1_n_rvalid", 64'(n_rvalid), 64'd0);
        chk("t1_mem_idle", 64'(mem_en), 64'd0);

        // 2: round-robin, both reading continuously
        do_reset();
        prio_mode = 0;
        c_req = 1; c_addr = 32'h30; n_req = 1; n_addr = 32'h40;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cyc();
            smp();
            chk($sformatf("t2_c_gnt%0d", i), 64'(c_gnt), 64'(i % 2 == 0));
            chk($sformatf("t2_n_gnt%0d", i), 64'(n_gnt), 64'(i % 2 == 1));
            chk($sformatf("t2_stall%0d", i), 64'(c_stall), 64'(i % 2 == 1));
            chk($sformatf("t2_c_rv%0d", i), 64'(c_rvalid), 64'(i >= 2 && i % 2 == 0));
            chk($sformatf("t2_n_rv%0d", i), 64'(n_rvalid), 64'(i >= 2 && i % 2 == 1));
            if (i == 2) chk("t2_c_rdata", c_rdata, 64'h3333);
            if (i == 3) chk("t2_n_rdata", n_rdata, 64'h4444);
        end
        cyc(); idle();
        smp();
        chk("t2_c_rv6", 64'(c_rvalid), 64'd1);
        chk("t2_c_cnt", 64'(c_gnt_cnt), 64'd3);
        chk("t2_n_cnt", 64'(n_gnt_cnt), 64'd3);
        cyc();
        smp();
        chk("t2_n_rv7", 64'(n_rvalid), 64'd1);
        chk("t2_c_rv7", 64'(c_rvalid), 64'd0);

        // 3: fixed priority, then switch to round-robin
        do_reset();
        prio_mode = 1;
        c_req = 1; c_addr = 32'h30; n_req = 1; n_addr = 32'h40;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            smp();
            chk($sformatf("t3_c_gnt%0d", i), 64'(c_gnt), 64'd1);
            chk($sformatf("t3_n_gnt%0d", i), 64'(n_gnt), 64'd0);
        end
        cyc(); prio_mode = 0;
        smp();
        chk("t3_sw_n_gnt", 64'(n_gnt), 64'd1);
        chk("t3_sw_c_gnt", 64'(c_gnt), 64'd0);
        chk("t3_sw_stall", 64'(c_stall), 64'd1);
        cyc(); idle();
        smp();
        chk("t3_c_cnt", 64'(c_gnt_cnt), 64'd4);
        chk("t3_n_cnt", 64'(n_gnt_cnt), 64'd1);

        // 4: NIC write then core read of the same address
        do_reset();
        n_req = 1; n_we = 1; n_addr = 32'h20; n_wdata = 64'h1234;
        smp();
        chk("t4_n_gnt", 64'(n_gnt), 64'd1);
        cyc(); idle(); c_req = 1; c_addr = 32'h20;
        smp();
        chk("t4_c_gnt", 64'(c_gnt), 64'd1);
        chk("t4_mem_en", 64'(mem_en), 64'd1);
        chk("t4_mem_we", 64'(mem_we), 64'd1);
        chk("t4_mem_addr", 64'(mem_addr), 64'h20);
        chk("t4_mem_din", mem_din, 64'h1234);
        cyc(); idle();
        smp();
        chk("t4_rd_we", 64'(mem_we), 64'd0);
        chk("t4_rd_en", 64'(mem_en), 64'd1);
        chk("t4_wr_no_rv", 64'(n_rvalid), 64'd0);
        cyc();
        smp();
        chk("t4_c_rvalid", 64'(c_rvalid), 64'd1);
        chk("t4_c_rdata", c_rdata, 64'h1234);

        // 5: reset right after a granted read
        do_reset();
        c_req = 1; c_addr = 32'h10;
        smp();
        chk("t5_c_gnt", 64'(c_gnt), 64'd1);
        cyc(); rst = 1; c_req = 1; n_req = 1;
        smp();
        chk("t5_rst_c_gnt", 64'(c_gnt), 64'd0);
        chk("t5_rst_n_gnt", 64'(n_gnt), 64'd0);
        chk("t5_rst_stall", 64'(c_stall), 64'd1);
        chk("t5_rst_mem_en", 64'(mem_en), 64'd0);
        cyc(); rst = 0; idle();
        smp();
        chk("t5_mem_en", 64'(mem_en), 64'd0);
        chk("t5_c_rv", 64'(c_rvalid), 64'd0);
        chk("t5_c_cnt", 64'(c_gnt_cnt), 64'd0);
        cyc();
        smp();
        chk("t5_c_rv2", 64'(c_rvalid), 64'd0);
        chk("t5_mem_en2", 64'(mem_en), 64'd0);

        // 6: counter saturation at 0xF
        do_reset();
        c_req = 1; c_addr = 32'h10;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) cyc();
            smp();
            if (i == 14) chk("t6_cnt14", 64'(c_gnt_cnt), 64'd14);
            if (i == 15) chk("t6_cnt15", 64'(c_gnt_cnt), 64'hF);
            if (i == 17) chk("t6_cnt17", 64'(c_gnt_cnt), 64'hF);
        end
        cyc(); idle();
        smp();
        chk("t6_cnt_end", 64'(c_gnt_cnt), 64'hF);
        chk("t6_n_cnt", 64'(n_gnt_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
